// File: rtl/mips_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_pkg
// Description : Shared constants for the wait-state multicycle MIPS controller:
//               FSM state codes, opcode/funct values, ALU/mux encodings,
//               trap cause codes and the ALU-control class type.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_mc_pkg;

    // FSM state codes
    localparam logic [3:0] c_st_fetch  = 4'd0;
    localparam logic [3:0] c_st_decode = 4'd1;
    localparam logic [3:0] c_st_memadr = 4'd2;
    localparam logic [3:0] c_st_memrd  = 4'd3;
    localparam logic [3:0] c_st_memwb  = 4'd4;
    localparam logic [3:0] c_st_memwr  = 4'd5;
    localparam logic [3:0] c_st_exec   = 4'd6;
    localparam logic [3:0] c_st_aluwb  = 4'd7;
    localparam logic [3:0] c_st_branch = 4'd8;
    localparam logic [3:0] c_st_immex  = 4'd9;
    localparam logic [3:0] c_st_immwb  = 4'd10;
    localparam logic [3:0] c_st_jump   = 4'd11;
    localparam logic [3:0] c_st_trap   = 4'd12;

    // Opcodes
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_bne   = 6'b000101;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_andi  = 6'b001100;
    localparam logic [5:0] c_op_ori   = 6'b001101;
    localparam logic [5:0] c_op_j     = 6'b000010;

    // R-type funct codes
    localparam logic [5:0] c_fn_add = 6'b100000;
    localparam logic [5:0] c_fn_sub = 6'b100010;
    localparam logic [5:0] c_fn_and = 6'b100100;
    localparam logic [5:0] c_fn_or  = 6'b100101;
    localparam logic [5:0] c_fn_slt = 6'b101010;

    // ALU operation encodings
    localparam logic [2:0] c_alu_add = 3'b010;
    localparam logic [2:0] c_alu_sub = 3'b110;
    localparam logic [2:0] c_alu_and = 3'b000;
    localparam logic [2:0] c_alu_or  = 3'b001;
    localparam logic [2:0] c_alu_slt = 3'b111;

    // ALU B source select
    localparam logic [1:0] c_srcb_reg   = 2'b00;
    localparam logic [1:0] c_srcb_four  = 2'b01;
    localparam logic [1:0] c_srcb_imm   = 2'b10;
    localparam logic [1:0] c_srcb_immsh = 2'b11;

    // PC source select
    localparam logic [1:0] c_pc_alu    = 2'b00;
    localparam logic [1:0] c_pc_aluout = 2'b01;
    localparam logic [1:0] c_pc_jump   = 2'b10;

    // Trap causes
    localparam logic [1:0] c_cause_none    = 2'b00;
    localparam logic [1:0] c_cause_illegal = 2'b01;
    localparam logic [1:0] c_cause_timeout = 2'b10;

    // Which family of ALU operation the current state needs
    typedef enum logic [1:0] {
        cls_add   = 2'd0,   // address / PC arithmetic
        cls_sub   = 2'd1,   // branch compare
        cls_funct = 2'd2,   // R-type, from funct field
        cls_imm   = 2'd3    // immediate ALU op, from opcode
    } alucls_t;

endpackage
`default_nettype wire

// File: rtl/mips_aludec.sv
`default_nettype none
// ============================================================================
// Module      : mips_aludec
// Description : ALU control decoder. Maps the state's ALU class, opcode and
//               funct field to the 3-bit ALU operation and flags R-type funct
//               values the core does not implement.
//   i_cls       : ALU class requested by the current FSM state
//   i_op        : opcode field
//   i_funct     : funct field
//   o_alu_ctl   : ALU operation
//   o_funct_bad : funct is not one of add/sub/and/or/slt
// Revision    : 1.0 - initial release
// ============================================================================
module mips_aludec
    import mips_mc_pkg::*;
(
    input  alucls_t      i_cls,
    input  logic [5:0]   i_op,
    input  logic [5:0]   i_funct,
    output logic [2:0]   o_alu_ctl,
    output logic         o_funct_bad
);

    logic [2:0] w_fn_ctl;
    logic       w_fn_bad;
    logic [2:0] w_imm_ctl;

    always_comb begin
        w_fn_ctl = c_alu_add;
        w_fn_bad = 1'b0;
        case (i_funct)
            c_fn_add: w_fn_ctl = c_alu_add;
            c_fn_sub: w_fn_ctl = c_alu_sub;
            c_fn_and: w_fn_ctl = c_alu_and;
            c_fn_or:  w_fn_ctl = c_alu_or;
            c_fn_slt: w_fn_ctl = c_alu_slt;
            default:  w_fn_bad = 1'b1;
        endcase
    end

    always_comb begin
        w_imm_ctl = c_alu_add;
        case (i_op)
            c_op_andi: w_imm_ctl = c_alu_and;
            c_op_ori:  w_imm_ctl = c_alu_or;
            default:   w_imm_ctl = c_alu_add;
        endcase
    end

    always_comb begin
        o_alu_ctl = c_alu_add;
        case (i_cls)
            cls_add:   o_alu_ctl = c_alu_add;
            cls_sub:   o_alu_ctl = c_alu_sub;
            cls_funct: o_alu_ctl = w_fn_ctl;
            cls_imm:   o_alu_ctl = w_imm_ctl;
            default:   o_alu_ctl = c_alu_add;
        endcase
    end

    assign o_funct_bad = w_fn_bad;

endmodule
`default_nettype wire

// File: rtl/mips_mc_ctrl_ws.sv
`default_nettype none
// ============================================================================
// Module      : mips_mc_ctrl_ws
// Description : Multicycle MIPS main controller with request/ready memory
//               handshake, memory timeout and illegal-opcode traps, and a
//               retired-instruction counter.
//   CLK, Reset          : clock, synchronous active-high reset
//   Op, Funct, Zero     : IR fields and ALU zero flag
//   MemReady            : memory completed the current request
//   MemReq, MemWrite    : memory request / store qualifier
//   IorD .. ExtOp       : single-bit datapath controls
//   ALUCtl, ALUSrcB,
//   PCSrc               : datapath mux / ALU selects
//   Trap, TrapCause     : halted flag and reason
//   Retired             : completed-instruction count (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_mc_ctrl_ws
    import mips_mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Funct,
    input  logic             Zero,
    input  logic             MemReady,
    output logic             MemReq,
    output logic             MemWrite,
    output logic             IorD,
    output logic             IRWrite,
    output logic             RegDst,
    output logic             MemToReg,
    output logic             ALUSrcA,
    output logic             RegWrite,
    output logic             PCEn,
    output logic             ExtOp,
    output logic [2:0]       ALUCtl,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       PCSrc,
    output logic             Trap,
    output logic [1:0]       TrapCause,
    output logic [CNT_W-1:0] Retired
);

    localparam logic [7:0] c_timeout = 8'(MEM_TIMEOUT);

    logic [3:0]       r_state;
    logic [7:0]       r_wait;
    logic [1:0]       r_cause;
    logic [CNT_W-1:0] r_retired;

    logic [3:0]       w_next;
    logic             w_retire;
    logic [1:0]       w_trap_cause;
    logic [7:0]       w_wait_inc;
    logic             w_timeout;
    alucls_t          w_cls;
    logic             w_funct_bad;

    mips_aludec u_aludec (
        .i_cls       (w_cls),
        .i_op        (Op),
        .i_funct     (Funct),
        .o_alu_ctl   (ALUCtl),
        .o_funct_bad (w_funct_bad)
    );

    // This wait cycle would be the MEM_TIMEOUT-th consecutive one. Only
    // consulted when MemReady is low, so a same-cycle ready always wins.
    assign w_wait_inc = r_wait + 8'(1);
    assign w_timeout  = (w_wait_inc >= c_timeout);

    // Next-state logic
    always_comb begin
        w_next       = r_state;
        w_retire     = 1'b0;
        w_trap_cause = c_cause_none;
        case (r_state)
            c_st_fetch: begin
                if (MemReady) begin
                    w_next = c_st_decode;
                end else if (w_timeout) begin
                    w_next       = c_st_trap;
                    w_trap_cause = c_cause_timeout;
                end
            end
            c_st_decode: begin
                case (Op)
                    c_op_lw, c_op_sw:               w_next = c_st_memadr;
                    c_op_beq, c_op_bne:             w_next = c_st_branch;
                    c_op_addi, c_op_andi, c_op_ori: w_next = c_st_immex;
                    c_op_j:                         w_next = c_st_jump;
                    c_op_rtype: begin
                        if (w_funct_bad) begin
                            w_next       = c_st_trap;
                            w_trap_cause = c_cause_illegal;
                        end else begin
                            w_next = c_st_exec;
                        end
                    end
                    default: begin
                        w_next       = c_st_trap;
                        w_trap_cause = c_cause_illegal;
                    end
                endcase
            end
            c_st_memadr: w_next = (Op == c_op_sw) ? c_st_memwr : c_st_memrd;
            c_st_memrd: begin
                if (MemReady) begin
                    w_next = c_st_memwb;
                end else if (w_timeout) begin
                    w_next       = c_st_trap;
                    w_trap_cause = c_cause_timeout;
                end
            end
            c_st_memwr: begin
                if (MemReady) begin
                    w_next   = c_st_fetch;
                    w_retire = 1'b1;
                end else if (w_timeout) begin
                    w_next       = c_st_trap;
                    w_trap_cause = c_cause_timeout;
                end
            end
            c_st_exec:  w_next = c_st_aluwb;
            c_st_immex: w_next = c_st_immwb;
            c_st_memwb, c_st_aluwb, c_st_branch, c_st_immwb, c_st_jump: begin
                w_next   = c_st_fetch;
                w_retire = 1'b1;
            end
            c_st_trap: w_next = c_st_trap;
            default:   w_next = c_st_fetch;
        endcase
    end

    // State, wait counter, trap cause and retired counter
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state   <= c_st_fetch;
            r_wait    <= 8'd0;
            r_cause   <= c_cause_none;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            // Counts only while the same request keeps waiting; any state
            // change (including into TRAP) or a ready restarts it.
            r_wait  <= (w_next == r_state && MemReq && !MemReady) ? w_wait_inc : 8'd0;
            if (w_next == c_st_trap && r_state != c_st_trap) begin
                r_cause <= w_trap_cause;
            end
            if (w_retire) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    // Moore outputs (plus the handshake/Zero qualified enables)
    always_comb begin
        MemReq   = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemToReg = 1'b0;
        ALUSrcA  = 1'b0;
        RegWrite = 1'b0;
        PCEn     = 1'b0;
        ExtOp    = 1'b0;
        ALUSrcB  = c_srcb_reg;
        PCSrc    = c_pc_alu;
        w_cls    = cls_add;
        case (r_state)
            c_st_fetch: begin
                MemReq  = 1'b1;
                ALUSrcB = c_srcb_four;
                IRWrite = MemReady;
                PCEn    = MemReady;
            end
            c_st_decode: ALUSrcB = c_srcb_immsh;
            c_st_memadr: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_srcb_imm;
                ExtOp   = 1'b1;
            end
            c_st_memrd: begin
                MemReq = 1'b1;
                IorD   = 1'b1;
            end
            c_st_memwr: begin
                MemReq   = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            c_st_memwb: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            c_st_exec: begin
                ALUSrcA = 1'b1;
                w_cls   = cls_funct;
            end
            c_st_aluwb: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            c_st_branch: begin
                ALUSrcA = 1'b1;
                w_cls   = cls_sub;
                PCSrc   = c_pc_aluout;
                PCEn    = (Op == c_op_bne) ? !Zero : Zero;
            end
            c_st_immex: begin
                ALUSrcA = 1'b1;
                ALUSrcB = c_srcb_imm;
                w_cls   = cls_imm;
                ExtOp   = (Op == c_op_addi);
            end
            // ALU op and extension held so the write-back sees a stable result
            c_st_immwb: begin
                RegWrite = 1'b1;
                w_cls    = cls_imm;
                ExtOp    = (Op == c_op_addi);
            end
            c_st_jump: begin
                PCSrc = c_pc_jump;
                PCEn  = 1'b1;
            end
            default: ;
        endcase
    end

    assign Trap      = (r_state == c_st_trap);
    assign TrapCause = r_cause;
    assign Retired   = r_retired;

endmodule
`default_nettype wire
